// File: rtl/ika9958_st_gen.sv
// ika9958_st_gen: screen-timing generator (H/V counters, sync, blanking, strobes).
// Define IKA9958_ST_HVADJ_EN to build the signed H/V display-adjust latches.
module ika9958_st_gen #(
    parameter int HW           = 9,
    parameter int VW           = 9,
    parameter int H_TOTAL      = 342,
    parameter int H_ACT_START  = 48,
    parameter int H_ACTIVE     = 256,
    parameter int HS_START     = 0,
    parameter int HS_WIDTH     = 26,
    parameter int V_TOTAL_NTSC = 262,
    parameter int V_TOTAL_PAL  = 313,
    parameter int V_ACT_START  = 16,
    parameter int VS_START     = 0,
    parameter int VS_WIDTH     = 3
) (
    input  logic          i_PHIA,
    input  logic          i_RST,
    input  logic          i_CEN_n,
    input  logic          i_PAL,
    input  logic          i_LN,
    input  logic          i_IL,
    input  logic [3:0]    i_HADJ,
    input  logic [3:0]    i_VADJ,
    output logic [HW-1:0] o_HCNT,
    output logic [VW-1:0] o_VCNT,
    output logic          o_HSYNC_n,
    output logic          o_VSYNC_n,
    output logic          o_HBLANK,
    output logic          o_VBLANK,
    output logic          o_DISP_EN,
    output logic          o_FIELD,
    output logic          o_LINE_START,
    output logic          o_FRAME_START,
    output logic          o_VINT
);

    localparam int AW = ((HW > VW) ? HW : VW) + 1;

    localparam logic [HW-1:0] HLAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] VT_N  = VW'(V_TOTAL_NTSC);
    localparam logic [VW-1:0] VT_P  = VW'(V_TOTAL_PAL);

    localparam logic [AW-1:0] A_HS0  = AW'(H_ACT_START);
    localparam logic [AW-1:0] A_HACT = AW'(H_ACTIVE);
    localparam logic [AW-1:0] A_HSS  = AW'(HS_START);
    localparam logic [AW-1:0] A_HSW  = AW'(HS_WIDTH);
    localparam logic [AW-1:0] A_VS0  = AW'(V_ACT_START);
    localparam logic [AW-1:0] A_VSS  = AW'(VS_START);
    localparam logic [AW-1:0] A_VSW  = AW'(VS_WIDTH);
    localparam logic [AW-1:0] A_L192 = AW'(192);
    localparam logic [AW-1:0] A_L212 = AW'(212);

    // Parameter legality: windows plus worst-case adjust must fit the totals.
    if (H_ACT_START < 8 || H_ACT_START + H_ACTIVE + 7 >= H_TOTAL) begin : g_bad_h
        $error("ika9958_st_gen: illegal horizontal window");
    end
    if (V_ACT_START < 8 || V_ACT_START + 212 + 7 >= V_TOTAL_NTSC ||
        V_ACT_START + 212 + 7 >= V_TOTAL_PAL) begin : g_bad_v
        $error("ika9958_st_gen: illegal vertical window");
    end
    if (H_TOTAL > (1 << HW) || V_TOTAL_NTSC + 1 > (1 << VW) ||
        V_TOTAL_PAL + 1 > (1 << VW)) begin : g_bad_w
        $error("ika9958_st_gen: counter width too small");
    end
    if (HS_START + HS_WIDTH > H_TOTAL ||
        VS_START + VS_WIDTH > V_TOTAL_NTSC) begin : g_bad_s
        $error("ika9958_st_gen: sync outside frame");
    end

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          field_q, field_d;
    logic          pal_q, pal_d;
    logic          ln_q, ln_d;
    logic          il_q, il_d;

    logic          hsync_n_q, hsync_n_d;
    logic          vsync_n_q, vsync_n_d;
    logic          hblank_q, hblank_d;
    logic          vblank_q, vblank_d;
    logic          disp_en_q, disp_en_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          vint_q, vint_d;

    logic [AW-1:0] hadj_x;
    logic [AW-1:0] vadj_x;

`ifdef IKA9958_ST_HVADJ_EN
    logic [3:0]    hadj_q, hadj_d;
    logic [3:0]    vadj_q, vadj_d;

    assign hadj_x = {{(AW-4){hadj_d[3]}}, hadj_d};
    assign vadj_x = {{(AW-4){vadj_d[3]}}, vadj_d};
`else
    logic          unused_adj;

    assign unused_adj = ^{i_HADJ, i_VADJ};
    assign hadj_x     = '0;
    assign vadj_x     = '0;
`endif

    logic [VW-1:0] vtot;
    logic          h_wrap;
    logic          f_wrap;

    // Counter, field and mode-latch next state; reset folds in here.
    always_comb begin
        vtot = pal_q ? VT_P : VT_N;
        if (il_q && !field_q) begin
            vtot = vtot + 1'b1;
        end
        h_wrap = (hcnt_q == HLAST);
        f_wrap = h_wrap && (vcnt_q == vtot - 1'b1);

        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        field_d = field_q;
        pal_d   = pal_q;
        ln_d    = ln_q;
        il_d    = il_q;
`ifdef IKA9958_ST_HVADJ_EN
        hadj_d  = hadj_q;
        vadj_d  = vadj_q;
`endif

        if (i_RST) begin
            hcnt_d  = '0;
            vcnt_d  = '0;
            field_d = 1'b0;
            pal_d   = i_PAL;
            ln_d    = i_LN;
            il_d    = i_IL;
`ifdef IKA9958_ST_HVADJ_EN
            hadj_d  = i_HADJ;
            vadj_d  = i_VADJ;
`endif
        end else if (!i_CEN_n) begin
            hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
            if (h_wrap) begin
                vcnt_d = f_wrap ? '0 : vcnt_q + 1'b1;
`ifdef IKA9958_ST_HVADJ_EN
                hadj_d = i_HADJ;
`endif
            end
            if (f_wrap) begin
                pal_d   = i_PAL;
                ln_d    = i_LN;
                il_d    = i_IL;
                field_d = i_IL & ~field_q;
`ifdef IKA9958_ST_HVADJ_EN
                vadj_d  = i_VADJ;
`endif
            end
        end
    end

    logic [AW-1:0] hx;
    logic [AW-1:0] vx;
    logic [AW-1:0] hs;
    logic [AW-1:0] vs;
    logic [AW-1:0] lines;
    logic [AW-1:0] vend;

    // Decode from next-state counters so outputs line up with o_HCNT/o_VCNT.
    // Window tests use (x - start) < width; x below start wraps to a huge value.
    always_comb begin
        hx    = {{(AW-HW){1'b0}}, hcnt_d};
        vx    = {{(AW-VW){1'b0}}, vcnt_d};
        hs    = A_HS0 + hadj_x;
        vs    = A_VS0 + vadj_x;
        lines = ln_d ? A_L212 : A_L192;
        vend  = vs + lines;

        hblank_d      = !((hx - hs) < A_HACT);
        vblank_d      = !((vx - vs) < lines);
        hsync_n_d     = !((hx - A_HSS) < A_HSW);
        vsync_n_d     = !((vx - A_VSS) < A_VSW);
        disp_en_d     = !hblank_d && !vblank_d;
        line_start_d  = (hcnt_d == '0);
        frame_start_d = line_start_d && (vcnt_d == '0);
        vint_d        = line_start_d && (vx == vend);
    end

    // State and registered decode.
    always_ff @(posedge i_PHIA) begin
        hcnt_q        <= hcnt_d;
        vcnt_q        <= vcnt_d;
        field_q       <= field_d;
        pal_q         <= pal_d;
        ln_q          <= ln_d;
        il_q          <= il_d;
        hsync_n_q     <= hsync_n_d;
        vsync_n_q     <= vsync_n_d;
        hblank_q      <= hblank_d;
        vblank_q      <= vblank_d;
        disp_en_q     <= disp_en_d;
        line_start_q  <= line_start_d;
        frame_start_q <= frame_start_d;
        vint_q        <= vint_d;
    end

`ifdef IKA9958_ST_HVADJ_EN
    // Adjust latches.
    always_ff @(posedge i_PHIA) begin
        hadj_q <= hadj_d;
        vadj_q <= vadj_d;
    end
`endif

    assign o_HCNT        = hcnt_q;
    assign o_VCNT        = vcnt_q;
    assign o_HSYNC_n     = hsync_n_q;
    assign o_VSYNC_n     = vsync_n_q;
    assign o_HBLANK      = hblank_q;
    assign o_VBLANK      = vblank_q;
    assign o_DISP_EN     = disp_en_q;
    assign o_FIELD       = field_q;
    assign o_LINE_START  = line_start_q;
    assign o_FRAME_START = frame_start_q;
    assign o_VINT        = vint_q;

endmodule

// File: tb/tb_ika9958_st_gen.sv
// tb_ika9958_st_gen: directed + randomized bench for ika9958_st_gen.
// Short lines keep frames cheap; vertical timing uses the default totals.
module tb_ika9958_st_gen;

    localparam int HT  = 24;
    localparam int HAS = 10;
    localparam int HA  = 4;
    localparam int HSS = 0;
    localparam int HSW = 3;
    localparam int VTN = 262;
    localparam int VTP = 313;
    localparam int VAS = 16;
    localparam int VSS = 0;
    localparam int VSW = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen_n;
    logic       pal;
    logic       ln;
    logic       il;
    logic [3:0] hadj;
    logic [3:0] vadj;

    logic [8:0] o_HCNT;
    logic [8:0] o_VCNT;
    logic       o_HSYNC_n, o_VSYNC_n, o_HBLANK, o_VBLANK;
    logic       o_DISP_EN, o_FIELD, o_LINE_START, o_FRAME_START, o_VINT;

    always #5 clk = ~clk;

    ika9958_st_gen #(
        .HW(9), .VW(9), .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACTIVE(HA),
        .HS_START(HSS), .HS_WIDTH(HSW), .V_TOTAL_NTSC(VTN),
        .V_TOTAL_PAL(VTP), .V_ACT_START(VAS), .VS_START(VSS),
        .VS_WIDTH(VSW)
    ) dut (
        .i_PHIA(clk), .i_RST(rst), .i_CEN_n(cen_n), .i_PAL(pal),
        .i_LN(ln), .i_IL(il), .i_HADJ(hadj), .i_VADJ(vadj),
        .o_HCNT(o_HCNT), .o_VCNT(o_VCNT), .o_HSYNC_n(o_HSYNC_n),
        .o_VSYNC_n(o_VSYNC_n), .o_HBLANK(o_HBLANK), .o_VBLANK(o_VBLANK),
        .o_DISP_EN(o_DISP_EN), .o_FIELD(o_FIELD),
        .o_LINE_START(o_LINE_START), .o_FRAME_START(o_FRAME_START),
        .o_VINT(o_VINT)
    );

    int checks = 0;
    int errors = 0;

    int m_h, m_v, m_hadj, m_vadj;
    bit m_field, m_pal, m_ln, m_il;
    bit rand_cen = 1'b0;

    logic [26:0] dut_vec;
    assign dut_vec = {o_HCNT, o_VCNT, o_HSYNC_n, o_VSYNC_n, o_HBLANK,
                      o_VBLANK, o_DISP_EN, o_FIELD, o_LINE_START,
                      o_FRAME_START, o_VINT};

`ifdef IKA9958_ST_HVADJ_EN
    function automatic int sx4(logic [3:0] x);
        return x[3] ? int'(x) - 16 : int'(x);
    endfunction
`endif

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: one clock edge of the screen position and its latches.
    task automatic model_edge();
        int vt;
        if (rst) begin
            m_h = 0;
            m_v = 0;
            m_field = 0;
            m_pal = pal;
            m_ln = ln;
            m_il = il;
`ifdef IKA9958_ST_HVADJ_EN
            m_hadj = sx4(hadj);
            m_vadj = sx4(vadj);
`else
            m_hadj = 0;
            m_vadj = 0;
`endif
        end else if (!cen_n) begin
            vt = (m_pal ? VTP : VTN) + ((m_il && !m_field) ? 1 : 0);
            m_h = (m_h + 1) % HT;
            if (m_h == 0) begin
`ifdef IKA9958_ST_HVADJ_EN
                m_hadj = sx4(hadj);
`endif
                m_v = (m_v + 1) % vt;
                if (m_v == 0) begin
                    m_pal = pal;
                    m_ln = ln;
                    m_il = il;
                    m_field = il ? !m_field : 1'b0;
`ifdef IKA9958_ST_HVADJ_EN
                    m_vadj = sx4(vadj);
`endif
                end
            end
        end
    endtask

    function automatic logic [26:0] model_out();
        int hs, vs, lines;
        bit hb, vb;
        hs = HAS + m_hadj;
        vs = VAS + m_vadj;
        lines = m_ln ? 212 : 192;
        hb = !(m_h >= hs && m_h < hs + HA);
        vb = !(m_v >= vs && m_v < vs + lines);
        return {9'(m_h), 9'(m_v),
                !(m_h >= HSS && m_h < HSS + HSW),
                !(m_v >= VSS && m_v < VSS + VSW),
                hb, vb, !hb && !vb, m_field, m_h == 0,
                m_h == 0 && m_v == 0,
                m_h == 0 && m_v == vs + lines};
    endfunction

    task automatic step();
        if (rand_cen) cen_n = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_edge();
        #1;
        chk("outputs", 32'(dut_vec), 32'(model_out()));
    endtask

    // Runs one whole frame from a frame start and records landmarks.
    task automatic run_frame(output int n, output int vint_v,
                             output int av0, output int av1,
                             output int ah0, output int ah1);
        n = 0;
        vint_v = -1;
        av0 = -1;
        av1 = -1;
        ah0 = -1;
        ah1 = -1;
        do begin
            step();
            n++;
            if (o_VINT && vint_v < 0) vint_v = int'(o_VCNT);
            if (!o_VBLANK) begin
                if (av0 < 0) av0 = int'(o_VCNT);
                av1 = int'(o_VCNT);
            end
            if (!o_HBLANK) begin
                if (ah0 < 0) ah0 = int'(o_HCNT);
                ah1 = int'(o_HCNT);
            end
        end while (!o_FRAME_START && n < 400 * HT);
        chk("frame_bound", 32'(o_FRAME_START), 32'd1);
    endtask

    initial begin
        int n, vi, av0, av1, ah0, ah1;

        rst = 1'b1;
        cen_n = 1'b0;
        pal = 1'b0;
        ln = 1'b0;
        il = 1'b0;
        hadj = 4'h0;
        vadj = 4'h0;
        step();
        chk("rst_hcnt", 32'(o_HCNT), 32'd0);
        chk("rst_vcnt", 32'(o_VCNT), 32'd0);
        chk("rst_fs", 32'(o_FRAME_START), 32'd1);
        chk("rst_disp", 32'(o_DISP_EN), 32'd0);
        rst = 1'b0;

        run_frame(n, vi, av0, av1, ah0, ah1);
        chk("ntsc_len", 32'(n), 32'(HT * 262));
        chk("ntsc_vint", 32'(vi), 32'd208);
        chk("ntsc_v0", 32'(av0), 32'd16);
        chk("ntsc_v1", 32'(av1), 32'd207);
        chk("ntsc_h0", 32'(ah0), 32'd10);
        chk("ntsc_h1", 32'(ah1), 32'd13);

        pal = 1'b1;
        ln = 1'b1;
        run_frame(n, vi, av0, av1, ah0, ah1);
        chk("pal_delay_len", 32'(n), 32'(HT * 262));
        run_frame(n, vi, av0, av1, ah0, ah1);
        chk("pal_len", 32'(n), 32'(HT * 313));
        chk("pal_vint", 32'(vi), 32'd228);
        chk("pal_v0", 32'(av0), 32'd16);
        chk("pal_v1", 32'(av1), 32'd227);

        pal = 1'b0;
        ln = 1'b0;
        il = 1'b1;
        run_frame(n, vi, av0, av1, ah0, ah1);
        chk("il_pal_len", 32'(n), 32'(HT * 313));
        chk("il_field1", 32'(o_FIELD), 32'd1);
        run_frame(n, vi, av0, av1, ah0, ah1);
        chk("il_f1_len", 32'(n), 32'(HT * 262));
        chk("il_field0", 32'(o_FIELD), 32'd0);
        il = 1'b0;
        run_frame(n, vi, av0, av1, ah0, ah1);
        chk("il_f0_len", 32'(n), 32'(HT * 263));
        chk("il_off_field", 32'(o_FIELD), 32'd0);

        hadj = 4'h8;
        vadj = 4'h7;
        run_frame(n, vi, av0, av1, ah0, ah1);
        run_frame(n, vi, av0, av1, ah0, ah1);
`ifdef IKA9958_ST_HVADJ_EN
        chk("adj_h0", 32'(ah0), 32'd2);
        chk("adj_h1", 32'(ah1), 32'd5);
        chk("adj_v0", 32'(av0), 32'd23);
        chk("adj_v1", 32'(av1), 32'd214);
        chk("adj_vint", 32'(vi), 32'd215);
`else
        chk("adj_h0", 32'(ah0), 32'd10);
        chk("adj_h1", 32'(ah1), 32'd13);
        chk("adj_v0", 32'(av0), 32'd16);
        chk("adj_v1", 32'(av1), 32'd207);
        chk("adj_vint", 32'(vi), 32'd208);
`endif

        rand_cen = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) hadj = 4'($urandom);
            if ($urandom_range(0, 499) == 0) vadj = 4'($urandom);
            if ($urandom_range(0, 499) == 0) {pal, ln, il} = 3'($urandom);
            step();
        end
        rand_cen = 1'b0;
        cen_n = 1'b0;

        n = 0;
        while (!(o_HCNT == 9'd12 && o_VCNT == 9'd100) && n < 9000) begin
            step();
            n++;
        end
        chk("reach_h", 32'(o_HCNT), 32'd12);
        chk("reach_v", 32'(o_VCNT), 32'd100);

        rst = 1'b1;
        cen_n = 1'b1;
        hadj = 4'h0;
        vadj = 4'h0;
        step();
        chk("mrst_hcnt", 32'(o_HCNT), 32'd0);
        chk("mrst_vcnt", 32'(o_VCNT), 32'd0);
        chk("mrst_field", 32'(o_FIELD), 32'd0);
        chk("mrst_fs", 32'(o_FRAME_START), 32'd1);
        chk("mrst_ls", 32'(o_LINE_START), 32'd1);
        chk("mrst_vint", 32'(o_VINT), 32'd0);
        chk("mrst_hblank", 32'(o_HBLANK), 32'd1);
        chk("mrst_vblank", 32'(o_VBLANK), 32'd1);
        chk("mrst_disp", 32'(o_DISP_EN), 32'd0);
        chk("mrst_hsync", 32'(o_HSYNC_n), 32'd0);
        chk("mrst_vsync", 32'(o_VSYNC_n), 32'd0);
        rst = 1'b0;
        cen_n = 1'b0;
        for (int i = 0; i < 50; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
